fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Sequencing controller for the fetch stage when instruction memory has variable latency. It owns the PC, issues one read at a time to the instruction memory, and buffers the returned word in a one-entry valid/ready buffer toward decode. It also applies branch/jump redirects, squashes stale in-flight fetches, and stops fetching on halt, misaligned target or memory error. It sits between the PC-select logic / decode and the instruction memory, in place of a free-running PC register and adder.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset.
NOP_INSTR, 16'h0800, value driven on instr whenever instr_valid=0.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
redirect  in  1  single-cycle pulse: fetch from redirect_pc next.
redirect_pc  in  16  redirect target; bit 0 must be 0.
halt  in  1  decode saw HALT; stop fetching permanently.
instr_ready  in  1  decode accepts the buffered instruction this cycle.
mem_done  in  1  memory returns data for the outstanding read.
mem_err  in  1  memory fault; qualified by mem_done.
mem_data  in  16  read data; valid when mem_done=1.
mem_rd  out  1  read strobe; one cycle per request.
mem_addr  out  16  read address (= pc register).
instr  out  16  buffered instruction.
instr_valid  out  1  instr / instr_pc / pc_plus2 are valid.
instr_pc  out  16  address of the buffered instruction.
pc_plus2  out  16  instr_pc + 2, modulo 2^16.
halted  out  1  sticky; set on entry to HALTED.
err  out  1  sticky; set on misaligned redirect or memory error.

Behaviour:
- Reset: state=FETCH, pc=RESET_PC, instr_valid=0, instr=NOP_INSTR, instr_pc=0, pc_plus2=2, squash=0, halted=0, err=0. Reset mid-access abandons the outstanding read, and any later mem_done is ignored until the next FETCH.
- States: FETCH, WAIT, HOLD, HALTED.
- Priority each cycle: halt > misaligned redirect > redirect > normal progress.
- mem_rd = (state==FETCH) & ~halt & ~redirect. mem_addr = pc at all times.
- FETCH:
  - no event: issue the read; next state WAIT.
  - redirect: pc<=redirect_pc, no read issued, stay FETCH; the read is issued the following cycle.
- WAIT: mem_rd=0; wait indefinitely for mem_done.
  - redirect before mem_done: pc<=redirect_pc, squash<=1.
  - redirect in the same cycle as mem_done: data discarded, pc<=redirect_pc, next state FETCH.
  - mem_done with squash=1: data discarded, squash<=0, next state FETCH.
  - mem_done with mem_err=1 and squash=0: err<=1, next state HALTED.
  - mem_done otherwise: instr<=mem_data, instr_pc<=pc, pc_plus2<=pc+2, pc<=pc+2 (16'hFFFE wraps to 16'h0000), instr_valid<=1, next state HOLD.
- HOLD: instr_valid=1, outputs stable while instr_ready=0 (no limit).
  - instr_ready=1: instr_valid<=0, instr<=NOP_INSTR, next state FETCH.
  - redirect: instr_valid<=0, pc<=redirect_pc, next state FETCH, regardless of instr_ready.
- Throughput: minimum 3 cycles per instruction (FETCH, WAIT with immediate mem_done, HOLD with instr_ready=1).
- Misaligned redirect (redirect=1, redirect_pc[0]=1) in any non-HALTED state: err<=1, instr_valid<=0, next state HALTED; pc unchanged.
- halt=1 in any non-HALTED state: instr_valid<=0, next state HALTED; outstanding read abandoned.
- HALTED: halted=1, mem_rd=0, instr_valid=0; all inputs ignored; exit only via rst.
- halted and err are set on the clock edge entering HALTED.

Test Plan:
- Reset, then mem_done one cycle after each mem_rd, instr_ready=1, mem_data=16'hA001,16'hA002 -> mem_addr 0 then 2; instr 16'hA001 with instr_pc=0, pc_plus2=2, then 16'hA002 with instr_pc=2; mem_rd pulses every 3 cycles.
- instr_ready held 0 for 5 cycles in HOLD -> instr_valid and instr stable, mem_rd=0 throughout; next fetch starts the cycle after instr_ready=1.
- redirect to 16'h0100 in WAIT, mem_done 3 cycles later with 16'hDEAD -> 16'hDEAD never valid; next mem_rd has mem_addr=16'h0100.
- pc=16'hFFFE, successful fetch -> instr_pc=16'hFFFE, pc_plus2=16'h0000, next mem_addr=16'h0000.
- redirect_pc=16'h0011 -> err=1, halted=1, mem_rd stays 0 for 10 cycles; rst -> mem_addr=RESET_PC, err=0, halted=0.
- mem_done with mem_err=1 -> err=1, halted=1, instr_valid stays 0; halt and redirect asserted in the same cycle -> HALTED with err=0 and pc unchanged.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Purpose : fetch-stage sequencer; owns the PC, issues one instruction read at a time, holds the returned word for decode.
// Latency : read strobe in FETCH, data captured on the mem_done edge, instr_valid the cycle after; at least 3 cycles per instruction.
// Backpressure: instr_valid stays high and outputs stay frozen while instr_ready=0; no new read is issued until the word is taken.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   redirect, redirect_pc      one-cycle PC redirect request and target (must be even)
//   halt                       decode saw HALT; stop fetching until reset
//   instr_ready                decode takes the buffered instruction
//   mem_done, mem_err, mem_data  completion, fault and data for the outstanding read
//   mem_rd, mem_addr           read strobe and address (address is the PC register)
//   instr, instr_valid, instr_pc, pc_plus2  buffered instruction toward decode
//   halted, err                sticky stop / fault flags
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        instr_ready,
  input  logic        mem_done,
  input  logic        mem_err,
  input  logic [15:0] mem_data,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        squash_q, squash_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;

  // A redirect with an odd target is a fault, not a jump.
  logic        bad_redirect;
  assign bad_redirect = redirect & redirect_pc[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= 16'h0000;
      pc_plus2_q <= 16'h0002;
      squash_q   <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_plus2_q <= pc_plus2_d;
      squash_q   <= squash_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_plus2_d = pc_plus2_q;
    squash_d   = squash_q;
    halted_d   = halted_q;
    err_d      = err_q;

    if (state_q != S_HALTED) begin
      if (halt) begin
        // Any outstanding read is simply abandoned; HALTED ignores mem_done.
        state_d  = S_HALTED;
        halted_d = 1'b1;
      end else if (bad_redirect) begin
        state_d  = S_HALTED;
        halted_d = 1'b1;
        err_d    = 1'b1;
      end else begin
        unique case (state_q)
          S_FETCH: begin
            if (redirect) begin
              pc_d = redirect_pc;
            end else begin
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (redirect) begin
              pc_d = redirect_pc;
              if (mem_done) begin
                // Read completed in the redirect cycle: drop it and refetch.
                squash_d = 1'b0;
                state_d  = S_FETCH;
              end else begin
                // Read still in flight for the old PC: its data must be dropped.
                squash_d = 1'b1;
              end
            end else if (mem_done) begin
              if (squash_q) begin
                squash_d = 1'b0;
                state_d  = S_FETCH;
              end else if (mem_err) begin
                state_d  = S_HALTED;
                halted_d = 1'b1;
                err_d    = 1'b1;
              end else begin
                instr_d    = mem_data;
                instr_pc_d = pc_q;
                pc_plus2_d = pc_q + 16'd2;
                pc_d       = pc_q + 16'd2;
                state_d    = S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (redirect) begin
              pc_d    = redirect_pc;
              state_d = S_FETCH;
            end else if (instr_ready) begin
              state_d = S_FETCH;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  // The buffer is full exactly while in HOLD; outside it decode sees a NOP.
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_valid ? instr_q : NOP_INSTR;
  assign instr_pc    = instr_pc_q;
  assign pc_plus2    = pc_plus2_q;
  assign mem_rd      = (state_q == S_FETCH) & ~halt & ~redirect;
  assign mem_addr    = pc_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule
